// File: rtl/mul_issue_ctrl_pkg.sv
// Shared ALU definitions for the EX stage: operation encoding, datapath width
// and the helper that classifies M-extension operations.
package mul_issue_ctrl_pkg;

   localparam int XLEN_WIDTH = 32;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_SLL,
      ALU_SRL,
      ALU_SRA,
      ALU_SLT,
      ALU_SLTU,
      ALU_MUL,
      ALU_MULH
   } alu_op_type;

   function automatic logic is_mul_op(input alu_op_type op);
      return (op == ALU_MUL) || (op == ALU_MULH);
   endfunction

endpackage

// File: rtl/mul_issue_ctrl.sv
// EX-stage sequencer for the chunked multiplier: issues M-ext ops, stalls until
// completion, keeps a one-entry result cache and drains the multiplier on flush.
module mul_issue_ctrl
   import mul_issue_ctrl_pkg::*;
#(
   parameter int NUM_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ex_valid,
   input  alu_op_type            ex_op,
   input  logic [XLEN_WIDTH-1:0] ex_rs1,
   input  logic [XLEN_WIDTH-1:0] ex_rs2,
   input  logic                  flush,
   output logic                  mul_start,
   output alu_op_type            mul_operation,
   output logic [XLEN_WIDTH-1:0] mul_operand1,
   output logic [XLEN_WIDTH-1:0] mul_operand2,
   input  logic [XLEN_WIDTH-1:0] mul_result,
   input  logic                  mul_finish,
   input  logic                  mul_ready,
   output logic                  stall_ex,
   output logic                  wb_valid,
   output logic [XLEN_WIDTH-1:0] wb_data,
   output logic                  mul_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} mic_state_t;

   // The watchdog is meaningless unless it outlasts a normal multiply.
   if (TIMEOUT_CYCLES <= NUM_CYCLES + 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must exceed NUM_CYCLES+1");
   end

   mic_state_t            state;
   mic_state_t            next_state;
   logic [CNT_W-1:0]      wait_cnt;
   logic                  cache_valid;
   alu_op_type            cache_op;
   logic [XLEN_WIDTH-1:0] cache_rs1;
   logic [XLEN_WIDTH-1:0] cache_rs2;
   logic [XLEN_WIDTH-1:0] cache_data;
   logic                  req;
   logic                  hit;
   logic                  timeout_hit;

   assign req         = ex_valid && is_mul_op(ex_op) && !flush;
   assign hit         = cache_valid && (cache_op == ex_op) &&
                        (cache_rs1 == ex_rs1) && (cache_rs2 == ex_rs2);
   assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

   always_comb begin
      next_state  = state;
      mul_start   = 1'b0;
      wb_valid    = 1'b0;
      mul_timeout = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  next_state = DONE;
               end else if (mul_ready) begin
                  mul_start  = 1'b1;
                  next_state = WAIT;
               end
            end
         end
         WAIT: begin
            // A flush landing together with finish behaves like a completed drain.
            if (mul_finish) begin
               next_state = flush ? IDLE : DONE;
            end else if (flush) begin
               next_state = DRAIN;
            end else if (timeout_hit) begin
               mul_timeout = 1'b1;
               next_state  = DONE;
            end
         end
         DONE: begin
            wb_valid   = !flush;
            next_state = IDLE;
         end
         DRAIN: begin
            if (mul_finish) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
      stall_ex = req && (state != DONE);
      if (reset) begin
         mul_start   = 1'b0;
         wb_valid    = 1'b0;
         mul_timeout = 1'b0;
         stall_ex    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         cache_valid   <= 1'b0;
         cache_op      <= ALU_MUL;
         cache_rs1     <= '0;
         cache_rs2     <= '0;
         cache_data    <= '0;
         mul_operation <= ALU_MUL;
         mul_operand1  <= '0;
         mul_operand2  <= '0;
         wb_data       <= '0;
      end else begin
         state <= next_state;
         if (mul_start) begin
            mul_operation <= ex_op;
            mul_operand1  <= ex_rs1;
            mul_operand2  <= ex_rs2;
            wait_cnt      <= '0;
         end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end
         if ((state == IDLE) && (next_state == DONE)) begin
            wb_data <= cache_data;
         end
         if ((state == WAIT) && mul_finish && !flush) begin
            cache_valid <= 1'b1;
            cache_op    <= mul_operation;
            cache_rs1   <= mul_operand1;
            cache_rs2   <= mul_operand2;
            cache_data  <= mul_result;
            wb_data     <= mul_result;
         end
         if (mul_timeout) begin
            cache_valid <= 1'b0;
            wb_data     <= '0;
         end
      end
   end

endmodule
